pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
Parametrised successor to the fixed EX/MEM latch: a generic one-stage pipeline register with a valid/ready handshake instead of a global stall vector. An optional 2-entry skid buffer breaks the ready path between stages. It supports synchronous flush with bubble insertion and a saturating back-pressure counter. It is placed between any two CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB) with DATA_W sized to that stage's bundle.

Parameters:
DATA_W, 64, width of the opaque payload bundle (rd, wreg, aluop, wdata, addr, pc, ... packed by the instantiator)
USE_SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
CNT_W, 16, width of the stall_cnt performance counter

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  reset, synchronous, active-high
flush  in  1  synchronous kill of all held entries (branch mispredict / exception)
in_valid  in  1  upstream payload valid
in_ready  out  1  this stage can accept this cycle
in_data  in  DATA_W  upstream payload
out_valid  out  1  payload presented downstream
out_ready  in  1  downstream accepts this cycle
out_data  out  DATA_W  presented payload; all-zero (NOP bubble) whenever out_valid=0
occupancy  out  2  entries held: 0, 1 or 2 (2 only when USE_SKID=1)
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Transfers: upstream fires on in_valid&&in_ready; downstream fires on out_valid&&out_ready. Latency is 1 cycle: data accepted at edge N appears on out_data after edge N.
- Registers: main (drives out_*), plus skid when USE_SKID=1. out_valid=main_valid. out_data=main_data, which is forced to 0 whenever main is loaded empty.
- USE_SKID=1 states, with in_ready = !skid_valid (register output only, no combinational path from out_ready):
  - EMPTY: in fire -> ONE (main<=in_data).
  - ONE: out fire and in fire -> ONE (main<=in_data). Out fire only -> EMPTY (main_data<=0). In fire with !out_ready -> TWO (skid<=in_data). Neither -> hold.
  - TWO: in_ready=0. Out fire -> ONE (main<=skid, skid_data<=0). Else hold.
- USE_SKID=0: in_ready = !main_valid || out_ready (combinational). Main loads on in fire. On out fire without in fire it empties and data is zeroed. Occupancy is never 2.
- Order is strictly FIFO. No payload is duplicated or dropped except by flush/rst.
- flush (same priority as rst for payload state): at the next edge, main_valid=skid_valid=0 and all data=0, so occupancy=0. An in_data presented in the flush cycle is discarded even if in_ready=1. in_ready is 1 in the cycle after flush. flush does not clear stall_cnt.
- rst: next edge clears all valids and data to 0 and stall_cnt to 0. It overrides flush and any handshake. Mid-operation reset loses held entries.
- Outputs after reset: out_valid=0, out_data=0, in_ready=1, occupancy=0, stall_cnt=0.
- stall_cnt: +1 each cycle with out_valid&&!out_ready. Holds at 2^CNT_W-1 (no wrap).
- out_valid and out_data must not depend combinationally on in_* or out_ready.

Test Plan:
- Reset, then in_valid=1 with in_data=0x11,0x22,0x33 on consecutive cycles, out_ready=1 -> out_data 0x11,0x22,0x33 one cycle later each; in_ready stays 1; occupancy 1.
- USE_SKID=1: load 0xA1, drop out_ready, present 0xB2 -> occupancy=2, in_ready=0, out_data holds 0xA1. Raise out_ready -> 0xA1 then 0xB2 delivered in order; stall_cnt increments once per held cycle.
- Flush while in TWO state with 0xC3 also presented -> next cycle out_valid=0, out_data=0, occupancy=0, in_ready=1. 0xC3 never appears on out_data.
- CNT_W=4, out_valid held with out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds. A subsequent flush leaves stall_cnt=15; rst sets it to 0.
- USE_SKID=0: main full, out_ready=1, in_valid=1 with 0x5A in the same cycle -> in_ready=1 that cycle and out_data=0x5A next cycle. With out_ready=0 -> in_ready=0 and occupancy never exceeds 1.
- rst asserted together with flush and in_valid=1 (0x77) -> next cycle all outputs at reset values; 0x77 is discarded.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// One-stage pipeline register with a valid/ready handshake between two CPU
// stages. With USE_SKID=1 a second entry absorbs the cycle of latency on the
// ready path, so in_ready is purely registered. Empty entries always carry
// all-zero data so an invalid slot reads as a NOP bubble downstream.
module pipe_stage_skid #(
    parameter int DATA_W   = 64,
    parameter int USE_SKID = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Saturating increment: the counter sticks at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic              main_vld_p1;
    logic [DATA_W-1:0] main_data_p1;
    logic              skid_vld_p1;
    logic [DATA_W-1:0] skid_data_p1;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = main_vld_p1 && out_ready;

    if (USE_SKID != 0) begin : g_skid
        // Ready depends only on the skid register, never on out_ready.
        assign in_ready = !skid_vld_p1;

        // Main/skid pair: the valid bits alone encode EMPTY, ONE and TWO.
        always_ff @(posedge clk) begin
            if (rst || flush) begin
                main_vld_p1  <= 1'b0;
                main_data_p1 <= '0;
                skid_vld_p1  <= 1'b0;
                skid_data_p1 <= '0;
            end else if (!main_vld_p1) begin
                if (in_fire) begin
                    main_vld_p1  <= 1'b1;
                    main_data_p1 <= in_data;
                end
            end else if (!skid_vld_p1) begin
                if (out_fire && in_fire) begin
                    main_data_p1 <= in_data;
                end else if (out_fire) begin
                    main_vld_p1  <= 1'b0;
                    main_data_p1 <= '0;
                end else if (in_fire) begin
                    skid_vld_p1  <= 1'b1;
                    skid_data_p1 <= in_data;
                end
            end else if (out_fire) begin
                main_data_p1 <= skid_data_p1;
                skid_vld_p1  <= 1'b0;
                skid_data_p1 <= '0;
            end
        end
    end else begin : g_single
        // Without a skid entry, a full stage accepts only when it drains this cycle.
        assign in_ready     = !main_vld_p1 || out_ready;
        assign skid_vld_p1  = 1'b0;
        assign skid_data_p1 = '0;

        // Single register: load on accept, drop to a zero bubble when drained.
        always_ff @(posedge clk) begin
            if (rst || flush) begin
                main_vld_p1  <= 1'b0;
                main_data_p1 <= '0;
            end else if (in_fire) begin
                main_vld_p1  <= 1'b1;
                main_data_p1 <= in_data;
            end else if (out_fire) begin
                main_vld_p1  <= 1'b0;
                main_data_p1 <= '0;
            end
        end
    end

    assign out_valid = main_vld_p1;
    assign out_data  = main_data_p1;
    assign occupancy = 2'(main_vld_p1) + 2'(skid_vld_p1);

    // Back-pressure counter: survives flush, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (main_vld_p1 && !out_ready) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: three instances share one stimulus stream
// (skid/16-bit counter, single-register/16-bit counter, skid/4-bit counter).
// A FIFO-with-capacity model predicts every output each cycle; a few literal
// expectations pin the model to hand-computed values.
module tb_pipe_stage_skid;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;

    logic       ir [3];
    logic       ov [3];
    logic [7:0] od [3];
    logic [1:0] occ [3];
    logic [15:0] sc_a, sc_b;
    logic [3:0]  sc_c;
    logic [15:0] sc [3];

    assign sc[0] = sc_a;
    assign sc[1] = sc_b;
    assign sc[2] = {12'd0, sc_c};

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(8), .USE_SKID(1), .CNT_W(16)) u_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
        .occupancy(occ[0]), .stall_cnt(sc_a));

    pipe_stage_skid #(.DATA_W(8), .USE_SKID(0), .CNT_W(16)) u_single (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
        .occupancy(occ[1]), .stall_cnt(sc_b));

    pipe_stage_skid #(.DATA_W(8), .USE_SKID(1), .CNT_W(4)) u_cnt4 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
        .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
        .occupancy(occ[2]), .stall_cnt(sc_c));

    // Model: a FIFO of capacity 2 (skid) or 1 (single) plus a stall counter.
    int         msz [3];
    logic [7:0] mdat [3][2];
    int         mcnt [3];
    int         n_chk  = 0;
    int         n_pass = 0;
    logic       chk_en = 1'b0;

    function automatic int cap(input int i);
        return (i == 1) ? 1 : 2;
    endfunction

    function automatic int cmax(input int i);
        return (i == 2) ? 15 : 65535;
    endfunction

    function automatic logic mready(input int i);
        if (i == 1) return (msz[i] == 0) || out_ready;
        return msz[i] < cap(i);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Advance the model by one clock edge using the inputs present before it.
    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            logic inf, outf;
            if (rst) begin
                msz[i]  = 0;
                mcnt[i] = 0;
            end else begin
                inf  = in_valid && mready(i);
                outf = (msz[i] > 0) && out_ready;
                if ((msz[i] > 0) && !out_ready && mcnt[i] < cmax(i)) mcnt[i]++;
                if (flush) begin
                    msz[i] = 0;
                end else begin
                    if (outf) begin
                        mdat[i][0] = mdat[i][1];
                        msz[i]--;
                    end
                    if (inf) begin
                        mdat[i][msz[i]] = in_data;
                        msz[i]++;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Every cycle, every instance: all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d.out_valid", i), 32'(ov[i]), 32'(msz[i] > 0));
                chk($sformatf("u%0d.out_data", i), 32'(od[i]),
                    (msz[i] > 0) ? 32'(mdat[i][0]) : 32'd0);
                chk($sformatf("u%0d.occupancy", i), 32'(occ[i]), 32'(msz[i]));
                chk($sformatf("u%0d.in_ready", i), 32'(ir[i]), 32'(mready(i)));
                chk($sformatf("u%0d.stall_cnt", i), 32'(sc[i]), 32'(mcnt[i]));
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            msz[i]  = 0;
            mcnt[i] = 0;
            mdat[i][0] = 8'h00;
            mdat[i][1] = 8'h00;
        end

        // Reset state
        tick();
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_out_valid", 32'(ov[i]), 32'd0);
            chk("rst_in_ready", 32'(ir[i]), 32'd1);
            chk("rst_occ", 32'(occ[i]), 32'd0);
        end
        rst = 1'b0;

        // Streaming at full rate
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data = 8'h11; tick(); chk("stream_11", 32'(od[0]), 32'h11);
        in_data = 8'h22; tick(); chk("stream_22", 32'(od[0]), 32'h22);
        in_data = 8'h33; tick(); chk("stream_33", 32'(od[0]), 32'h33);
        chk("stream_ir", 32'(ir[0]), 32'd1);
        chk("stream_occ", 32'(occ[0]), 32'd1);
        in_valid = 1'b0; tick();

        // Fill skid entry under back-pressure, then drain in order
        in_valid = 1'b1; in_data = 8'hA1; tick();
        out_ready = 1'b0; in_data = 8'hB2; tick();
        chk("two_occ", 32'(occ[0]), 32'd2);
        chk("two_ir", 32'(ir[0]), 32'd0);
        chk("two_hold", 32'(od[0]), 32'hA1);
        chk("single_occ", 32'(occ[1]), 32'd1);
        in_valid = 1'b0; tick();
        chk("two_stall", 32'(sc[0]), 32'd2);
        out_ready = 1'b1; tick();
        chk("drain_b2", 32'(od[0]), 32'hB2);
        tick();

        // Flush while two entries are held, with 0xC3 offered
        in_valid = 1'b1; in_data = 8'h44; tick();
        out_ready = 1'b0; in_data = 8'h55; tick();
        flush = 1'b1; in_data = 8'hC3; tick();
        chk("flush_ov", 32'(ov[0]), 32'd0);
        chk("flush_od", 32'(od[0]), 32'd0);
        chk("flush_occ", 32'(occ[0]), 32'd0);
        chk("flush_ir", 32'(ir[0]), 32'd1);
        flush = 1'b0; in_valid = 1'b0; tick();

        // Saturation of the 4-bit counter
        in_valid = 1'b1; in_data = 8'h66; tick();
        in_valid = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        chk("sat_15", 32'(sc[2]), 32'd15);
        chk("sat_24", 32'(sc[0]), 32'd24);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("sat_after_flush", 32'(sc[2]), 32'd15);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("sat_after_rst", 32'(sc[2]), 32'd0);

        // Single-register pass-through while full
        in_valid = 1'b1; in_data = 8'h10; tick();
        out_ready = 1'b1; in_data = 8'h5A; #1;
        chk("single_ir_pass", 32'(ir[1]), 32'd1);
        tick();
        chk("single_5a", 32'(od[1]), 32'h5A);
        out_ready = 1'b0; in_data = 8'h6B; #1;
        chk("single_ir_block", 32'(ir[1]), 32'd0);
        tick();
        chk("single_occ_max", 32'(occ[1]), 32'd1);
        chk("single_hold", 32'(od[1]), 32'h5A);

        // Reset overrides flush and a handshake
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 8'h77; tick();
        for (int i = 0; i < 3; i++) begin
            chk("rstf_ov", 32'(ov[i]), 32'd0);
            chk("rstf_od", 32'(od[i]), 32'd0);
            chk("rstf_sc", 32'(sc[i]), 32'd0);
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; tick();

        // Mixed valid/ready patterns for ordering
        for (int k = 0; k < 48; k++) begin
            in_valid  = (k % 3) != 0;
            out_ready = (k % 4) != 1 && (k % 7) != 3;
            in_data   = 8'(8'h80 + k);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick();

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
